// File: rtl/tl_request_scheduler.sv
// tl_request_scheduler
// Latches walk/pre-emption requests from N_REQ approaches as pending bits. At a
// sequencer safe point it offers one of them to the RYG phase sequencer through
// a valid/ack grant handshake. A watchdog bounds each service, and a cooldown
// counted in 1 s ticks follows it.
//
// Optional feature, controlled by the macro TL_SCHED_PRIORITY0_EN:
//   defined   - source 0 is an emergency source. It is picked whenever it is
//               pending, its grants leave rr_ptr unchanged, and a pending[0]
//               aborts COOLDOWN.
//   undefined - pure round-robin arbitration.
//
// Ports:
//   clk, rst_n      clock; asynchronous active-low reset
//   tick_1s         one-clk pulse per second
//   enable          1 = run mode; 0 flushes the scheduler to IDLE
//   req_pulse       one-clk request pulses, bit i = source i
//   safe_point      sequencer may accept a grant now
//   grant_valid     grant offered (registered)
//   grant_id        granted source, frozen while grant_valid=1
//   grant_ack       sequencer accepts the offered grant
//   service_done    sequencer finished the granted phase
//   busy            1 in OFFER/SERVE/COOLDOWN
//   pending         latched requests that have not been granted yet
//   timeout_pulse   one-clk pulse when the watchdog fires
module tl_request_scheduler #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int CNT_W       = 8,
    parameter int COOLDOWN_S  = 10,
    parameter int MAX_SERVE_S = 60
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_1s,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_pulse,
    input  logic             safe_point,
    output logic             grant_valid,
    output logic [ID_W-1:0]  grant_id,
    input  logic             grant_ack,
    input  logic             service_done,
    output logic             busy,
    output logic [N_REQ-1:0] pending,
    output logic             timeout_pulse
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] OFFER    = 2'd1;
    localparam logic [1:0] SERVE    = 2'd2;
    localparam logic [1:0] COOLDOWN = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  pick;
    logic [ID_W-1:0]  rr_next;
    logic [CNT_W-1:0] cnt;          // watchdog in SERVE, cooldown in COOLDOWN
    logic [N_REQ-1:0] pending_clr;
    logic             cnt_is_one;
    logic             adv_rr;

    assign busy       = (state != IDLE);
    assign cnt_is_one = (cnt == CNT_W'(1));

    // Round-robin pick: the first pending bit at or after rr_ptr, with wrap.
    always_comb begin
        int  idx;
        logic found;
        pick  = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % N_REQ;
            if (!found && pending[idx]) begin
                pick  = ID_W'(idx);
                found = 1'b1;
            end
        end
`ifdef TL_SCHED_PRIORITY0_EN
        if (pending[0]) pick = '0;
`endif
    end

    assign rr_next = (int'(grant_id) >= N_REQ - 1) ? '0 : grant_id + 1'b1;

`ifdef TL_SCHED_PRIORITY0_EN
    assign adv_rr = (grant_id != '0);
`else
    assign adv_rr = 1'b1;
`endif

    // Only an ack to an outstanding offer retires its pending bit. The
    // set/clear merge lets a same-cycle re-request for that bit win.
    assign pending_clr = (state == OFFER && grant_ack) ? (N_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            pending       <= '0;
            cnt           <= '0;
            rr_ptr        <= '0;
            grant_valid   <= 1'b0;
            grant_id      <= '0;
            timeout_pulse <= 1'b0;
        end else if (!enable) begin
            // Night/set mode flush. rr_ptr survives so fairness resumes.
            state         <= IDLE;
            pending       <= '0;
            cnt           <= '0;
            grant_valid   <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            pending       <= (pending & ~pending_clr) | req_pulse;
            timeout_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (|pending && safe_point) begin
                        state       <= OFFER;
                        grant_valid <= 1'b1;
                        grant_id    <= pick;
                    end
                end
                OFFER: begin
                    if (grant_ack) begin
                        state       <= SERVE;
                        grant_valid <= 1'b0;
                        cnt         <= CNT_W'(MAX_SERVE_S);
                        if (adv_rr) rr_ptr <= rr_next;
                    end else if (!safe_point) begin
                        // Withdraw the offer. The pending bit stays set, so
                        // the source is offered again at the next safe point.
                        state       <= IDLE;
                        grant_valid <= 1'b0;
                    end
                end
                SERVE: begin
                    // service_done has priority over a coincident final tick.
                    if (service_done || (tick_1s && cnt_is_one)) begin
                        timeout_pulse <= !service_done;
                        if (COOLDOWN_S == 0) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            state <= COOLDOWN;
                            cnt   <= CNT_W'(COOLDOWN_S);
                        end
                    end else if (tick_1s && cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                COOLDOWN: begin
`ifdef TL_SCHED_PRIORITY0_EN
                    if (pending[0]) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else
`endif
                    if (tick_1s) begin
                        if (cnt <= CNT_W'(1)) begin
                            state <= IDLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tl_request_scheduler.sv
module tb_tl_request_scheduler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick_1s = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] req_pulse = 4'b0;
    logic       safe_point = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_id;
    logic       grant_ack = 1'b0;
    logic       service_done = 1'b0;
    logic       busy;
    logic [3:0] pending;
    logic       timeout_pulse;

    int checks = 0;
    int errors = 0;

    tl_request_scheduler dut (
        .clk(clk), .rst_n(rst_n), .tick_1s(tick_1s), .enable(enable),
        .req_pulse(req_pulse), .safe_point(safe_point),
        .grant_valid(grant_valid), .grant_id(grant_id), .grant_ack(grant_ack),
        .service_done(service_done), .busy(busy), .pending(pending),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick_1s = 1'b1;
            step();
            tick_1s = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(); step();
        checks++;
        if ({grant_valid, busy, pending, timeout_pulse, grant_id} !== 9'b0) begin
            errors++;
            $display("FAIL reset_state: got gv=%b busy=%b pend=%b to=%b id=%0d, want all 0",
                     grant_valid, busy, pending, timeout_pulse, grant_id);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_round_robin();
        enable = 1'b1; safe_point = 1'b1;
        req_pulse = 4'b0110; step(); req_pulse = 4'b0;
        checks++;
        if (pending !== 4'b0110) begin
            errors++; $display("FAIL rr_latch: pending=%b want 0110", pending);
        end
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd1) begin
            errors++; $display("FAIL rr_first_grant: gv=%b id=%0d want gv=1 id=1", grant_valid, grant_id);
        end
        grant_ack = 1'b1; step(); grant_ack = 1'b0;
        checks++;
        if (grant_valid !== 1'b0 || pending !== 4'b0100 || busy !== 1'b1) begin
            errors++; $display("FAIL rr_ack: gv=%b pend=%b busy=%b want 0 0100 1", grant_valid, pending, busy);
        end
        service_done = 1'b1; step(); service_done = 1'b0;
        ticks(9);
        checks++;
        if (busy !== 1'b1 || grant_valid !== 1'b0) begin
            errors++; $display("FAIL cooldown_hold: busy=%b gv=%b want 1 0", busy, grant_valid);
        end
        ticks(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL cooldown_end: busy=%b want 0", busy);
        end
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
            errors++; $display("FAIL rr_second_grant: gv=%b id=%0d want gv=1 id=2", grant_valid, grant_id);
        end
        grant_ack = 1'b1; step(); grant_ack = 1'b0;
        checks++;
        if (dut.rr_ptr !== 2'd3) begin
            errors++; $display("FAIL rr_ptr_adv: rr_ptr=%0d want 3", dut.rr_ptr);
        end
        service_done = 1'b1; step(); service_done = 1'b0;
        ticks(10);
    endtask

    task automatic test_withdraw();
        req_pulse = 4'b0100; step(); req_pulse = 4'b0;
        step();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
            errors++; $display("FAIL withdraw_offer: gv=%b id=%0d want 1 2", grant_valid, grant_id);
        end
        safe_point = 1'b0; step();
        checks++;
        if (grant_valid !== 1'b0 || pending !== 4'b0100 || busy !== 1'b0) begin
            errors++; $display("FAIL withdraw: gv=%b pend=%b busy=%b want 0 0100 0", grant_valid, pending, busy);
        end
        step();
        safe_point = 1'b1; step();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== 2'd2) begin
            errors++; $display("FAIL regrant: gv=%b id=%0d want 1 2", grant_valid, grant_id);
        end
        grant_ack = 1'b1; step(); grant_ack = 1'b0;
    endtask

    task automatic test_watchdog();
        ticks(59);
        checks++;
        if (timeout_pulse !== 1'b0 || dut.state !== 2'd2) begin
            errors++; $display("FAIL wd_early: to=%b state=%0d want 0 2", timeout_pulse, dut.state);
        end
        ticks(1);
        checks++;
        if (timeout_pulse !== 1'b1 || dut.state !== 2'd3) begin
            errors++; $display("FAIL wd_fire: to=%b state=%0d want 1 3", timeout_pulse, dut.state);
        end
        step();
        checks++;
        if (timeout_pulse !== 1'b0) begin
            errors++; $display("FAIL wd_pulse_width: to=%b want 0", timeout_pulse);
        end
    endtask

    task automatic test_disable();
        req_pulse = 4'b1000; step(); req_pulse = 4'b0;
        checks++;
        if (pending !== 4'b1000 || busy !== 1'b1) begin
            errors++; $display("FAIL cooldown_latch: pend=%b busy=%b want 1000 1", pending, busy);
        end
        enable = 1'b0; step();
        checks++;
        if (pending !== 4'b0000 || busy !== 1'b0 || grant_valid !== 1'b0) begin
            errors++; $display("FAIL disable_flush: pend=%b busy=%b gv=%b want 0000 0 0", pending, busy, grant_valid);
        end
        req_pulse = 4'b1000; step(); req_pulse = 4'b0;
        checks++;
        if (pending !== 4'b0000) begin
            errors++; $display("FAIL disable_ignore_req: pend=%b want 0000", pending);
        end
        enable = 1'b1; step();
    endtask

    task automatic test_priority();
        logic [1:0] exp_id;
`ifdef TL_SCHED_PRIORITY0_EN
        exp_id = 2'd0;
`else
        exp_id = 2'd2;
`endif
        // Grant source 1 so that rr_ptr becomes 2.
        req_pulse = 4'b0010; step(); req_pulse = 4'b0;
        step();
        grant_ack = 1'b1; step(); grant_ack = 1'b0;
        checks++;
        if (dut.rr_ptr !== 2'd2) begin
            errors++; $display("FAIL prio_setup: rr_ptr=%0d want 2", dut.rr_ptr);
        end
        service_done = 1'b1; step(); service_done = 1'b0;
        ticks(10);
        safe_point = 1'b0;
        req_pulse = 4'b0101; step(); req_pulse = 4'b0;
        safe_point = 1'b1; step();
        checks++;
        if (grant_valid !== 1'b1 || grant_id !== exp_id) begin
            errors++; $display("FAIL prio_pick: gv=%b id=%0d want 1 %0d", grant_valid, grant_id, exp_id);
        end
        // Re-request of the bit being acked in the same cycle keeps it pending.
        grant_ack = 1'b1; req_pulse = 4'b0001 << exp_id; step();
        grant_ack = 1'b0; req_pulse = 4'b0;
        checks++;
        if (pending !== 4'b0101 || dut.state !== 2'd2) begin
            errors++; $display("FAIL set_wins: pend=%b state=%0d want 0101 2", pending, dut.state);
        end
    endtask

    task automatic test_reset_mid_serve();
        rst_n = 1'b0;
        #2;
        checks++;
        if (grant_valid !== 1'b0 || busy !== 1'b0 || pending !== 4'b0) begin
            errors++; $display("FAIL reset_mid_serve: gv=%b busy=%b pend=%b want 0 0 0000", grant_valid, busy, pending);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_withdraw();
        test_watchdog();
        test_disable();
        test_priority();
        test_reset_mid_serve();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
